// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
//   Bundles every non-clock, non-reset signal of the fetch controller: the
//   decode-side controls (stall, branch redirect), the instruction-memory
//   req/ack handshake and the fetch buffer outputs.
//
//   Modports:
//     master - the fetch controller (drives imem_req/imem_addr, pc, fetch
//              buffer, flush, fetch_err; samples stall, branch, ack, rdata)
//     slave  - the surroundings (decode stage + instruction memory)
// -----------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 64
);
    // decode side
    logic              stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;

    // instruction memory
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    // fetch stage state
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_valid;
    logic              flush;
    logic              fetch_err;

    modport master (
        input  stall, br_taken, br_target, imem_ack, imem_rdata,
        output imem_req, imem_addr, pc, instr, instr_addr, instr_valid,
               flush, fetch_err
    );

    modport slave (
        output stall, br_taken, br_target, imem_ack, imem_rdata,
        input  imem_req, imem_addr, pc, instr, instr_addr, instr_valid,
               flush, fetch_err
    );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencing controller. Owns the PC and a one-entry
//   fetch buffer and talks to a variable-latency instruction memory through a
//   req/ack handshake. Handles decode stalls, branch redirects (with a
//   deferred redirect when a request is still in flight), flush generation
//   and fetch-error detection (misaligned redirect, optional ack timeout).
//
//   Ports:
//     clk    - clock, all state updates on the rising edge
//     reset  - asynchronous active-low reset
//     bus    - fetch_ctrl_if.master: stall, br_taken/br_target,
//              imem_req/imem_addr/imem_ack/imem_rdata, pc, instr,
//              instr_addr, instr_valid, flush, fetch_err
//
//   Parameters:
//     ADDR_W   - PC / memory address width
//     RESET_PC - PC value loaded on reset
//     MAX_WAIT - ack wait limit in cycles (only with FETCH_TIMEOUT_EN)
//
//   Build option:
//     FETCH_TIMEOUT_EN - when defined, an outstanding request that waits
//                        MAX_WAIT cycles without ack raises fetch_err.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       MAX_WAIT = 15
) (
    input logic          clk,
    input logic          reset,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        BOOT,   // single settling cycle after reset release
        FETCH,  // request outstanding to instruction memory
        HOLD,   // buffer full and decode stalled: no request
        HALT    // fatal fetch error, left only by reset
    } state_e;

    state_e            state_q,       state_d;
    logic [ADDR_W-1:0] pc_q,          pc_d;
    logic [31:0]       instr_q,       instr_d;
    logic [ADDR_W-1:0] instr_addr_q,  instr_addr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              flush_q,       flush_d;
    logic              fetch_err_q,   fetch_err_d;
    logic              redir_pend_q,  redir_pend_d;
    logic [ADDR_W-1:0] redir_tgt_q,   redir_tgt_d;

    logic req;         // request is on the bus this cycle
    logic ack;         // ack qualified by an active request
    logic consume;     // decode takes the buffered instruction this cycle
    logic misaligned;  // redirect target not word aligned
    logic timeout;     // outstanding request waited too long

    assign req        = (state_q == FETCH);
    assign ack        = req & bus.imem_ack;
    assign consume    = instr_valid_q & ~bus.stall;
    assign misaligned = (bus.br_target[1:0] != 2'b00);

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counts cycles spent waiting on an unacked request; the cycle that would
    // bring it to MAX_WAIT raises the error.
    assign timeout    = req & ~bus.imem_ack & (wait_cnt_q >= WAIT_W'(MAX_WAIT - 1));
    assign wait_cnt_d = (req & ~bus.imem_ack & ~bus.br_taken & ~timeout)
                      ? wait_cnt_q + WAIT_W'(1) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    // Without the timeout the memory may take arbitrarily long.
    logic unused_max_wait;
    assign unused_max_wait = |MAX_WAIT;
    assign timeout         = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath decisions
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_addr_d  = instr_addr_q;
        instr_valid_d = instr_valid_q;
        flush_d       = 1'b0;
        fetch_err_d   = fetch_err_q;
        redir_pend_d  = redir_pend_q;
        redir_tgt_d   = redir_tgt_q;

        // Decode draining the buffer empties it unless refilled below.
        if (consume) begin
            instr_valid_d = 1'b0;
        end

        if (state_q == HALT) begin
            instr_valid_d = 1'b0;
        end else begin
            flush_d = bus.br_taken;

            if (timeout || (bus.br_taken && misaligned)) begin
                fetch_err_d   = 1'b1;
                instr_valid_d = 1'b0;
                state_d       = HALT;
            end else if (bus.br_taken) begin
                instr_valid_d = 1'b0;
                state_d       = FETCH;
                if (req && !bus.imem_ack) begin
                    // Address must stay stable until the in-flight request is
                    // acked; remember where to go and apply it on that ack.
                    redir_pend_d = 1'b1;
                    redir_tgt_d  = bus.br_target;
                end else begin
                    // Nothing in flight (or its data arrives now and is
                    // dropped): jump straight away.
                    pc_d         = bus.br_target;
                    redir_pend_d = 1'b0;
                end
            end else begin
                unique case (state_q)
                    BOOT: state_d = FETCH;

                    HOLD: begin
                        if (consume) begin
                            state_d = FETCH;
                        end
                    end

                    FETCH: begin
                        if (ack) begin
                            if (redir_pend_q) begin
                                // Returned word belongs to the squashed path.
                                pc_d         = redir_tgt_q;
                                redir_pend_d = 1'b0;
                                if (instr_valid_d) begin
                                    state_d = HOLD;
                                end
                            end else if (instr_valid_d) begin
                                // Buffer still full and decode stalled: the
                                // word is dropped and pc kept, so it is
                                // fetched again once the buffer drains.
                                state_d = HOLD;
                            end else begin
                                instr_d       = bus.imem_rdata;
                                instr_addr_d  = pc_q;
                                instr_valid_d = 1'b1;
                                pc_d          = pc_q + ADDR_W'(4);
                                if (bus.stall) begin
                                    state_d = HOLD;
                                end
                            end
                        end
                    end

                    default: state_d = state_q;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_addr_q  <= '0;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            fetch_err_q   <= 1'b0;
            redir_pend_q  <= 1'b0;
            redir_tgt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            instr_valid_q <= instr_valid_d;
            flush_q       <= flush_d;
            fetch_err_q   <= fetch_err_d;
            redir_pend_q  <= redir_pend_d;
            redir_tgt_q   <= redir_tgt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_addr  = instr_addr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.flush       = flush_q;
    assign bus.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Self-checking bench for fetch_ctrl: a directed vector table, a few
//   hand-written multi-cycle sequences (async reset in HALT, ack timeout,
//   pc wrap) and a long randomized run against a transaction-level model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_ctrl;

    localparam int unsigned    AW     = 64;
    localparam logic [AW-1:0]  RST_PC = '0;
    localparam int unsigned    MAXW   = 15;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fetch_ctrl_if #(.ADDR_W(AW)) bus ();

    fetch_ctrl #(.ADDR_W(AW), .RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory content: a simple address-derived pattern.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5EED_0000;
    endfunction

    // -------------------------------------------------------------------------
    // Reference model: what the fetch stage promises, cycle by cycle.
    // -------------------------------------------------------------------------
    bit            m_booting, m_halted, m_paused;
    logic [63:0]   m_pc, m_baddr;
    logic [31:0]   m_bword;
    bit            m_bv, m_flush, m_err;
    logic [63:0]   m_redir[$];
    int            m_waited;

    task automatic model_reset();
        m_booting = 1; m_halted = 0; m_paused = 0;
        m_pc = RST_PC; m_baddr = '0; m_bword = '0;
        m_bv = 0; m_flush = 0; m_err = 0;
        m_redir.delete();
        m_waited = 0;
    endtask

    task automatic model_step(input bit s, input bit b, input logic [63:0] t, input bit a);
        bit asking, timed_out;
        asking = !m_booting && !m_halted && !m_paused;
        if (m_bv && !s) m_bv = 0;          // decode takes the word
        m_flush = 0;
        if (m_halted) begin
            m_bv = 0;
            return;
        end
        timed_out = TMO && asking && !a && (m_waited + 1 >= int'(MAXW));
        m_waited  = (asking && !a && !b) ? m_waited + 1 : 0;
        m_flush   = b;
        if (timed_out || (b && t[1:0] != 2'b00)) begin
            m_halted = 1; m_err = 1; m_bv = 0;
        end else if (b) begin
            m_bv = 0;
            if (asking && !a) begin
                m_redir.delete();
                m_redir.push_back(t);
            end else begin
                m_pc = t;
                m_redir.delete();
                m_booting = 0;
                m_paused  = 0;
            end
        end else if (m_booting) begin
            m_booting = 0;
        end else if (m_paused) begin
            if (!m_bv) m_paused = 0;
        end else if (a) begin
            if (m_redir.size() > 0) begin
                m_pc     = m_redir.pop_front();
                m_paused = m_bv;
            end else if (m_bv) begin
                m_paused = 1;                 // no room: word thrown away
            end else begin
                m_bword  = mem_word(m_pc);
                m_baddr  = m_pc;
                m_bv     = 1;
                m_pc     = m_pc + 64'd4;
                m_paused = s;
            end
        end
    endtask

    task automatic compare_model();
        check("imem_req",    64'(bus.imem_req),    64'(!m_booting && !m_halted && !m_paused));
        check("imem_addr",   bus.imem_addr,        m_pc);
        check("pc",          bus.pc,               m_pc);
        check("instr_valid", 64'(bus.instr_valid), 64'(m_bv));
        check("instr_addr",  bus.instr_addr,       m_baddr);
        check("instr",       64'(bus.instr),       64'(m_bword));
        check("flush",       64'(bus.flush),       64'(m_flush));
        check("fetch_err",   64'(bus.fetch_err),   64'(m_err));
    endtask

    // Called 1 time unit after a rising edge; drives one cycle of inputs.
    task automatic step(input bit s, input bit b, input logic [63:0] t, input bit a);
        bus.stall      = s;
        bus.br_taken   = b;
        bus.br_target  = t;
        bus.imem_ack   = a;
        bus.imem_rdata = mem_word(bus.imem_addr);
        @(posedge clk);
        #1;
        model_step(s, b, t, a);
        compare_model();
    endtask

    // Asynchronous reset applied away from the clock edge.
    task automatic do_reset();
        bus.stall = 0; bus.br_taken = 0; bus.br_target = '0;
        bus.imem_ack = 0; bus.imem_rdata = '0;
        reset = 1'b0;
        #2;
        model_reset();
        compare_model();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Directed vector table
    // -------------------------------------------------------------------------
    typedef struct {
        bit          s, b, a;
        logic [63:0] t;
        bit          e_req, e_valid, e_flush, e_err;
        logic [63:0] e_pc, e_iaddr;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input bit s, input bit b, input logic [63:0] t, input bit a,
                                input bit req, input bit vld, input logic [63:0] ia,
                                input logic [63:0] pc, input bit fl, input bit er);
        vec_t v;
        v.s = s; v.b = b; v.t = t; v.a = a;
        v.e_req = req; v.e_valid = vld; v.e_iaddr = ia; v.e_pc = pc;
        v.e_flush = fl; v.e_err = er;
        return v;
    endfunction

    initial begin
        //           s  b  target   a   req vld iaddr  pc     fl er
        tbl[0]  = mk(0, 0, 64'h0,   1,  1,  0,  'h0,   'h0,   0, 0); // BOOT -> FETCH
        tbl[1]  = mk(0, 0, 64'h0,   1,  1,  1,  'h0,   'h4,   0, 0);
        tbl[2]  = mk(0, 0, 64'h0,   1,  1,  1,  'h4,   'h8,   0, 0);
        tbl[3]  = mk(0, 0, 64'h0,   1,  1,  1,  'h8,   'hC,   0, 0);
        tbl[4]  = mk(0, 0, 64'h0,   1,  1,  1,  'hC,   'h10,  0, 0); // pc=16 after 4th ack
        tbl[5]  = mk(0, 0, 64'h0,   0,  1,  0,  'hC,   'h10,  0, 0); // ack withheld
        tbl[6]  = mk(0, 0, 64'h0,   0,  1,  0,  'hC,   'h10,  0, 0);
        tbl[7]  = mk(0, 0, 64'h0,   0,  1,  0,  'hC,   'h10,  0, 0);
        tbl[8]  = mk(0, 0, 64'h0,   1,  1,  1,  'h10,  'h14,  0, 0); // late word lands
        tbl[9]  = mk(1, 0, 64'h0,   1,  0,  1,  'h10,  'h14,  0, 0); // stall -> HOLD
        tbl[10] = mk(1, 0, 64'h0,   1,  0,  1,  'h10,  'h14,  0, 0); // ack ignored
        tbl[11] = mk(0, 0, 64'h0,   1,  1,  0,  'h10,  'h14,  0, 0); // drained, resume
        tbl[12] = mk(0, 0, 64'h0,   1,  1,  1,  'h14,  'h18,  0, 0);
        tbl[13] = mk(0, 1, 64'h100, 0,  1,  0,  'h14,  'h18,  1, 0); // redirect in flight
        tbl[14] = mk(0, 0, 64'h0,   1,  1,  0,  'h14,  'h100, 0, 0); // stale data dropped
        tbl[15] = mk(0, 0, 64'h0,   1,  1,  1,  'h100, 'h104, 0, 0);
        tbl[16] = mk(0, 1, 64'h200, 1,  1,  0,  'h100, 'h200, 1, 0); // redirect with ack
        tbl[17] = mk(0, 0, 64'h0,   1,  1,  1,  'h200, 'h204, 0, 0);
        tbl[18] = mk(0, 1, 64'h302, 0,  0,  0,  'h200, 'h204, 1, 1); // misaligned
        tbl[19] = mk(0, 1, 64'h400, 1,  0,  0,  'h200, 'h204, 0, 1); // HALT ignores all
    end

    // Global guard so the run always ends.
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1);
    end

    initial begin
        int ack_pct;
        logic [63:0] tgt;
        bit s, b, a;

        #1;
        do_reset();

        // ---- directed table ----
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].s, tbl[i].b, tbl[i].t, tbl[i].a);
            check($sformatf("tbl%0d.req", i),   64'(bus.imem_req),    64'(tbl[i].e_req));
            check($sformatf("tbl%0d.valid", i), 64'(bus.instr_valid), 64'(tbl[i].e_valid));
            check($sformatf("tbl%0d.iaddr", i), bus.instr_addr,       tbl[i].e_iaddr);
            check($sformatf("tbl%0d.pc", i),    bus.pc,               tbl[i].e_pc);
            check($sformatf("tbl%0d.flush", i), 64'(bus.flush),       64'(tbl[i].e_flush));
            check($sformatf("tbl%0d.err", i),   64'(bus.fetch_err),   64'(tbl[i].e_err));
        end

        // ---- reset asserted in the middle of HALT acts immediately ----
        bus.stall = 0; bus.br_taken = 0; bus.imem_ack = 0;
        reset = 1'b0;
        #2;
        check("halt_reset.pc",  bus.pc,               RST_PC);
        check("halt_reset.err", 64'(bus.fetch_err),   64'd0);
        check("halt_reset.req", 64'(bus.imem_req),    64'd0);
        check("halt_reset.vld", 64'(bus.instr_valid), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ---- pc wraps modulo 2^ADDR_W ----
        step(0, 0, 64'h0, 0);                          // BOOT
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);        // immediate redirect
        step(0, 0, 64'h0, 1);
        check("wrap.pc",    bus.pc,         64'h0);
        check("wrap.iaddr", bus.instr_addr, 64'hFFFF_FFFF_FFFF_FFFC);

        // ---- ack withheld: timeout or unlimited wait ----
        do_reset();
        step(0, 0, 64'h0, 0);                          // BOOT -> FETCH
`ifdef FETCH_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            step(0, 0, 64'h0, 0);
            check($sformatf("tmo.err@%0d", i), 64'(bus.fetch_err), 64'(i == 15));
        end
        check("tmo.req", 64'(bus.imem_req), 64'd0);
`else
        for (int i = 1; i <= 100; i++) step(0, 0, 64'h0, 0);
        check("notmo.err",  64'(bus.fetch_err), 64'd0);
        check("notmo.req",  64'(bus.imem_req),  64'd1);
        check("notmo.addr", bus.imem_addr,      RST_PC);
`endif

        // ---- randomized run against the model ----
        do_reset();
        ack_pct = 70;
        for (int c = 0; c < 4000; c++) begin
            if (c % 100 == 0) ack_pct = $urandom_range(3, 100);
            if (m_halted && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                s = ($urandom_range(0, 2) == 0);
                b = ($urandom_range(0, 11) == 0);
                a = ($urandom_range(1, 100) <= ack_pct);
                case ($urandom_range(0, 15))
                    0:       tgt = {$urandom, $urandom} | 64'h1;
                    1:       tgt = 64'hFFFF_FFFF_FFFF_FFF8;
                    default: tgt = {$urandom, $urandom} & ~64'h3;
                endcase
                step(s, b, tgt, a);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
